// File: rtl/cria_pkts_hdr.sv
// Event-packet header generator: NetFPGA module header + Ethernet/IPv4/UDP words built from ring registers.
// Optional IPv4 header checksum: define CRIA_PKTS_IP_CKSUM_EN (otherwise the checksum field is 0).
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module cria_pkts_hdr #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = 8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int NUM_WORDS_PAYLOAD = 20,
  parameter int HEADER_LENGTH     = 7,
  parameter int REG_BASE_ADDR     = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              reg_req_in,
  input  logic                              reg_ack_in,
  input  logic                              reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in,
  output logic                              reg_req_out,
  output logic                              reg_ack_out,
  output logic                              reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,
  input  logic [2:0]                        header_word_number,
  input  logic                              evt_pkt_sent,
  output logic [DATA_WIDTH-1:0]             header_data,
  output logic [CTRL_WIDTH-1:0]             header_ctrl,
  output logic                              enable
);

  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [15:0] WL   = 16'(HEADER_LENGTH - 1 + NUM_WORDS_PAYLOAD);
  localparam logic [15:0] BL   = 16'((HEADER_LENGTH - 1 + NUM_WORDS_PAYLOAD) * 8);
  localparam logic [15:0] IPL  = 16'((HEADER_LENGTH - 1 + NUM_WORDS_PAYLOAD) * 8 - 14);
  localparam logic [15:0] UDPL = 16'((HEADER_LENGTH - 1 + NUM_WORDS_PAYLOAD) * 8 - 34);

  logic        ctrl_q, ctrl_d;
  logic [15:0] out_port_q, out_port_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [31:0] udp_ports_q, udp_ports_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] seq_q, seq_d;

  logic                         req_q, ack_q, rd_wr_l_q;
  logic [AW-1:0]                addr_q;
  logic [DW-1:0]                data_q;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q;

  logic [AW-1:0] rel_addr;
  logic [3:0]    reg_off;
  logic          in_blk, claim, wr_en;
  logic [31:0]   rd_data;
  logic [15:0]   ip_cksum;
  logic [63:0]   hdr_w;
  logic [CTRL_WIDTH-1:0] hdr_c;

  assign rel_addr = reg_addr_in - AW'(REG_BASE_ADDR);
  assign in_blk   = (rel_addr[AW-1:4] == '0);
  assign reg_off  = rel_addr[3:0];
  assign claim    = reg_req_in && !reg_ack_in && in_blk;
  assign wr_en    = claim && !reg_rd_wr_L_in;

  always_comb begin
    ctrl_d      = ctrl_q;
    out_port_d  = out_port_q;
    dst_mac_d   = dst_mac_q;
    src_mac_d   = src_mac_q;
    src_ip_d    = src_ip_q;
    dst_ip_d    = dst_ip_q;
    udp_ports_d = udp_ports_q;
    pkt_cnt_d   = pkt_cnt_q;
    seq_d       = seq_q;
    if (evt_pkt_sent) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      seq_d     = seq_q + 32'd1;
    end
    if (wr_en) begin
      case (reg_off)
        4'd0: ctrl_d             = reg_data_in[0];
        4'd1: out_port_d         = reg_data_in[15:0];
        4'd2: dst_mac_d[47:32]   = reg_data_in[15:0];
        4'd3: dst_mac_d[31:0]    = reg_data_in[31:0];
        4'd4: src_mac_d[47:32]   = reg_data_in[15:0];
        4'd5: src_mac_d[31:0]    = reg_data_in[31:0];
        4'd6: src_ip_d           = reg_data_in[31:0];
        4'd7: dst_ip_d           = reg_data_in[31:0];
        4'd8: udp_ports_d        = reg_data_in[31:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      4'd0:  rd_data = {31'd0, ctrl_q};
      4'd1:  rd_data = {16'd0, out_port_q};
      4'd2:  rd_data = {16'd0, dst_mac_q[47:32]};
      4'd3:  rd_data = dst_mac_q[31:0];
      4'd4:  rd_data = {16'd0, src_mac_q[47:32]};
      4'd5:  rd_data = src_mac_q[31:0];
      4'd6:  rd_data = src_ip_q;
      4'd7:  rd_data = dst_ip_q;
      4'd8:  rd_data = udp_ports_q;
      4'd9:  rd_data = pkt_cnt_q;
      4'd10: rd_data = seq_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q      <= 1'b0;
      out_port_q  <= 16'h0001;
      dst_mac_q   <= '0;
      src_mac_q   <= '0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      udp_ports_q <= '0;
      pkt_cnt_q   <= '0;
      seq_q       <= '0;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      rd_wr_l_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      src_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      out_port_q  <= out_port_d;
      dst_mac_q   <= dst_mac_d;
      src_mac_q   <= src_mac_d;
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      udp_ports_q <= udp_ports_d;
      pkt_cnt_q   <= pkt_cnt_d;
      seq_q       <= seq_d;
      req_q       <= reg_req_in;
      ack_q       <= reg_ack_in || claim;
      rd_wr_l_q   <= reg_rd_wr_L_in;
      addr_q      <= reg_addr_in;
      src_q       <= reg_src_in;
      // Claimed reads replace the ring data; everything else rides through untouched.
      data_q      <= (claim && reg_rd_wr_L_in) ? DW'(rd_data) : reg_data_in;
    end
  end

  assign reg_req_out     = req_q;
  assign reg_ack_out     = ack_q;
  assign reg_rd_wr_L_out = rd_wr_l_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;
  assign enable          = ctrl_q;

`ifdef CRIA_PKTS_IP_CKSUM_EN
  function automatic logic [15:0] ip_cksum_f(input logic [15:0] seq16,
                                             input logic [31:0] sip,
                                             input logic [31:0] dip);
    logic [31:0] s;
    s = 32'h4500 + {16'd0, IPL} + {16'd0, seq16} + 32'h4000 + 32'h4011
      + {16'd0, sip[31:16]} + {16'd0, sip[15:0]}
      + {16'd0, dip[31:16]} + {16'd0, dip[15:0]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  assign ip_cksum = ip_cksum_f(seq_q[15:0], src_ip_q, dst_ip_q);
`else
  assign ip_cksum = 16'h0000;
`endif

  always_comb begin
    hdr_w = '0;
    hdr_c = '0;
    if (int'(header_word_number) < HEADER_LENGTH) begin
      case (header_word_number)
        3'd0: begin
          hdr_w = {out_port_q, WL, 16'h0000, BL};
          hdr_c = {CTRL_WIDTH{1'b1}};
        end
        3'd1: hdr_w = {dst_mac_q, src_mac_q[47:32]};
        3'd2: hdr_w = {src_mac_q[31:0], 16'h0800, 8'h45, 8'h00};
        3'd3: hdr_w = {IPL, seq_q[15:0], 16'h4000, 8'h40, 8'h11};
        3'd4: hdr_w = {ip_cksum, src_ip_q, dst_ip_q[31:16]};
        3'd5: hdr_w = {dst_ip_q[15:0], udp_ports_q, UDPL};
        3'd6: hdr_w = {16'h0000, seq_q, 16'h0000};
        default: hdr_w = '0;
      endcase
    end
  end

  assign header_data = DATA_WIDTH'(hdr_w);
  assign header_ctrl = hdr_c;

endmodule

// File: tb/tb_cria_pkts_hdr.sv
// Directed bench for cria_pkts_hdr: ring register access, header words, sequence counting, reset.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_cria_pkts_hdr;
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;

`ifdef CRIA_PKTS_IP_CKSUM_EN
  // Hand-folded: 4500+00C2+0000+4000+4011+C0A8+0001+C0A8+0002 = 0x24726 -> 0x4728 -> ~ = 0xB8D7
  localparam logic [15:0] EXP_CK = 16'hB8D7;
`else
  localparam logic [15:0] EXP_CK = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [DW-1:0] reg_data_in = '0;
  logic [1:0]    reg_src_in = '0;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [1:0]    reg_src_out;
  logic [2:0]    header_word_number = '0;
  logic          evt_pkt_sent = 1'b0;
  logic [63:0]   header_data;
  logic [7:0]    header_ctrl;
  logic          enable;

  int checks = 0;
  int failures = 0;

  cria_pkts_hdr dut (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .header_word_number(header_word_number), .evt_pkt_sent(evt_pkt_sent),
    .header_data(header_data), .header_ctrl(header_ctrl), .enable(enable)
  );

  always #5 clk = ~clk;

  task automatic ring(input logic req, input logic ack, input logic rdwr,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] src);
    @(negedge clk);
    reg_req_in = req; reg_ack_in = ack; reg_rd_wr_L_in = rdwr;
    reg_addr_in = addr; reg_data_in = data; reg_src_in = src;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ring(1'b1, 1'b0, 1'b0, addr, data, 2'd0);
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    ring(1'b1, 1'b0, 1'b1, addr, '0, 2'd0);
    data = reg_data_out;
    idle();
  endtask

  task automatic set_n(input logic [2:0] n);
    header_word_number = n;
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    set_n(3'd0);
    checks++; if (header_ctrl !== 8'hFF) begin failures++; $display("FAIL rst_w0_ctrl got=%h exp=ff", header_ctrl); end
    checks++; if (header_data !== 64'h0001_001A_0000_00D0) begin failures++; $display("FAIL rst_w0 got=%h exp=0001001a000000d0", header_data); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rst_enable got=%b exp=0", enable); end
    checks++; if ({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out} !== '0) begin
      failures++; $display("FAIL rst_ring got=%b%b%b %h %h %h exp=0", reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out); end
    set_n(3'd1);
    checks++; if (header_ctrl !== 8'h00) begin failures++; $display("FAIL rst_w1_ctrl got=%h exp=00", header_ctrl); end
    set_n(3'd2);
    checks++; if (header_data !== 64'h0000_0000_0800_4500) begin failures++; $display("FAIL rst_w2 got=%h exp=0000000008004500", header_data); end
    set_n(3'd5);
    checks++; if (header_data !== 64'h0000_0000_0000_00AE) begin failures++; $display("FAIL rst_w5 got=%h exp=00000000000000ae", header_data); end
    set_n(3'd7);
    checks++; if (header_data !== 64'h0 || header_ctrl !== 8'h0) begin failures++; $display("FAIL rst_w7 got=%h/%h exp=0/0", header_data, header_ctrl); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ctrl();
    logic [DW-1:0] d;
    ring(1'b1, 1'b0, 1'b0, 23'd0, 32'h1, 2'd1);
    checks++; if (reg_ack_out !== 1'b1 || reg_req_out !== 1'b1 || reg_rd_wr_L_out !== 1'b0) begin
      failures++; $display("FAIL ctrl_wr_ack got=req%b ack%b rw%b exp=req1 ack1 rw0", reg_req_out, reg_ack_out, reg_rd_wr_L_out); end
    checks++; if (reg_data_out !== 32'h1 || reg_src_out !== 2'd1) begin failures++; $display("FAIL ctrl_wr_pass got=%h/%0d exp=1/1", reg_data_out, reg_src_out); end
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL ctrl_enable got=%b exp=1", enable); end
    idle();
    rd(23'd0, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL ctrl_rd got=%h exp=00000001", d); end
    wr(23'd1, 32'hABCD_1234);
    rd(23'd1, d);
    checks++; if (d !== 32'h0000_1234) begin failures++; $display("FAIL outport_rd got=%h exp=00001234", d); end
    set_n(3'd0);
    checks++; if (header_data !== 64'h1234_001A_0000_00D0) begin failures++; $display("FAIL outport_w0 got=%h exp=1234001a000000d0", header_data); end
  endtask

  task automatic test_mac();
    logic [DW-1:0] d;
    wr(23'd2, 32'hFFFF_0011);
    wr(23'd3, 32'h2233_4455);
    wr(23'd4, 32'h0000_0066);
    wr(23'd5, 32'h7788_99AA);
    rd(23'd2, d);
    checks++; if (d !== 32'h0000_0011) begin failures++; $display("FAIL dmac_hi_rd got=%h exp=00000011", d); end
    set_n(3'd1);
    checks++; if (header_data !== 64'h0011_2233_4455_0066) begin failures++; $display("FAIL w1 got=%h exp=0011223344550066", header_data); end
    set_n(3'd2);
    checks++; if (header_data !== 64'h7788_99AA_0800_4500) begin failures++; $display("FAIL w2 got=%h exp=778899aa08004500", header_data); end
  endtask

  task automatic test_ip_udp();
    wr(23'd6, 32'hC0A8_0001);
    wr(23'd7, 32'hC0A8_0002);
    wr(23'd8, 32'h1234_5678);
    set_n(3'd3);
    checks++; if (header_data !== 64'h00C2_0000_4000_4011) begin failures++; $display("FAIL w3_seq0 got=%h exp=00c2000040004011", header_data); end
    set_n(3'd4);
    checks++; if (header_data !== {EXP_CK, 48'hC0A8_0001_C0A8}) begin failures++; $display("FAIL w4 got=%h exp=%h", header_data, {EXP_CK, 48'hC0A8_0001_C0A8}); end
    set_n(3'd5);
    checks++; if (header_data !== 64'h0002_1234_5678_00AE) begin failures++; $display("FAIL w5 got=%h exp=00021234567800ae", header_data); end
  endtask

  task automatic test_seq();
    logic [DW-1:0] d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); evt_pkt_sent = 1'b1;
      @(negedge clk); evt_pkt_sent = 1'b0;
    end
    rd(23'd9, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL pkt_cnt got=%0d exp=3", d); end
    rd(23'd10, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL seq got=%0d exp=3", d); end
    set_n(3'd3);
    checks++; if (header_data !== 64'h00C2_0003_4000_4011) begin failures++; $display("FAIL w3_seq3 got=%h exp=00c2000340004011", header_data); end
    set_n(3'd6);
    checks++; if (header_data !== 64'h0000_0000_0003_0000) begin failures++; $display("FAIL w6_seq3 got=%h exp=0000000000030000", header_data); end
    wr(23'd10, 32'h55);
    wr(23'd9, 32'h77);
    rd(23'd10, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL seq_ro got=%0d exp=3", d); end
    rd(23'd9, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL pkt_cnt_ro got=%0d exp=3", d); end
    wr(23'd11, 32'hFFFF_FFFF);
    rd(23'd11, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL off11_rd got=%h exp=0", d); end
  endtask

  task automatic test_coincide();
    logic [DW-1:0] d;
    @(negedge clk);
    evt_pkt_sent = 1'b1;
    reg_req_in = 1; reg_ack_in = 0; reg_rd_wr_L_in = 0; reg_addr_in = 23'd0; reg_data_in = 32'h0;
    @(posedge clk); #1;
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL coinc_enable got=%b exp=0", enable); end
    @(negedge clk); evt_pkt_sent = 1'b0;
    idle();
    rd(23'd10, d);
    checks++; if (d !== 32'd4) begin failures++; $display("FAIL coinc_seq got=%0d exp=4", d); end
  endtask

  task automatic test_passthru();
    ring(1'b1, 1'b1, 1'b0, 23'd0, 32'h1, 2'd3);
    checks++; if ({reg_req_out, reg_ack_out, reg_rd_wr_L_out} !== 3'b110 || reg_addr_out !== 23'd0 || reg_data_out !== 32'h1 || reg_src_out !== 2'd3) begin
      failures++; $display("FAIL pass_acked got=%b%b%b %h %h %0d exp=110 0 1 3", reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL pass_acked_enable got=%b exp=0", enable); end
    ring(1'b1, 1'b0, 1'b1, 23'h10, 32'hDEAD_BEEF, 2'd2);
    checks++; if ({reg_req_out, reg_ack_out, reg_rd_wr_L_out} !== 3'b101 || reg_addr_out !== 23'h10 || reg_data_out !== 32'hDEAD_BEEF || reg_src_out !== 2'd2) begin
      failures++; $display("FAIL pass_outside got=%b%b%b %h %h %0d exp=101 10 deadbeef 2", reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out); end
    ring(1'b1, 1'b0, 1'b0, 23'h10, 32'h1, 2'd1);
    checks++; if (enable !== 1'b0 || reg_ack_out !== 1'b0) begin failures++; $display("FAIL pass_outside_wr got=en%b ack%b exp=en0 ack0", enable, reg_ack_out); end
    ring(1'b0, 1'b0, 1'b0, 23'd0, 32'h1, 2'd0);
    checks++; if (enable !== 1'b0 || reg_ack_out !== 1'b0 || reg_req_out !== 1'b0) begin failures++; $display("FAIL pass_noreq got=en%b ack%b req%b exp=0 0 0", enable, reg_ack_out, reg_req_out); end
    idle();
  endtask

  task automatic test_reset_mid();
    wr(23'd0, 32'h1);
    ring(1'b1, 1'b0, 1'b1, 23'd10, 32'h0, 2'd1);
    checks++; if (reg_data_out !== 32'd4 || reg_ack_out !== 1'b1) begin failures++; $display("FAIL pre_rst_rd got=%h ack%b exp=4 ack1", reg_data_out, reg_ack_out); end
    #2 reset = 1'b0;
    #1;
    checks++; if (enable !== 1'b0 || reg_ack_out !== 1'b0 || reg_data_out !== 32'd0 || reg_src_out !== 2'd0) begin
      failures++; $display("FAIL mid_rst_ring got=en%b ack%b %h %0d exp=0 0 0 0", enable, reg_ack_out, reg_data_out, reg_src_out); end
    set_n(3'd6);
    checks++; if (header_data !== 64'h0) begin failures++; $display("FAIL mid_rst_w6 got=%h exp=0", header_data); end
    set_n(3'd0);
    checks++; if (header_data !== 64'h0001_001A_0000_00D0) begin failures++; $display("FAIL mid_rst_w0 got=%h exp=0001001a000000d0", header_data); end
    idle();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_mac();
    test_ip_udp();
    test_seq();
    test_coincide();
    test_passthru();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
